// File: rtl/can_fd_tx_bit_stuffer.sv
// CAN FD transmit bit stuffer: dynamic and fixed stuff-bit insertion, stuff
// counting for the ISO CRC field, arbitration-loss and bit-error detection.
module can_fd_tx_bit_stuffer #(
    parameter int unsigned STUFF_RUN = 5,
    parameter int unsigned FIXED_RUN = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             tx_point_i,
    input  logic             sample_point_i,
    input  logic             rx_i,
    input  logic             arb_i,
    input  logic             fixed_stuff_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             bit_ready_o,
    output logic             tx_o,
    output logic             stuff_bit_o,
    output logic [CNT_W-1:0] stuff_count_o,
    output logic             arb_lost_o,
    output logic             bit_err_o,
    output logic             underrun_o
);
    localparam int unsigned RUN_W = $clog2(STUFF_RUN + 1);
    localparam int unsigned FIX_W = $clog2(FIXED_RUN + 1);

    logic             r_tx;
    logic             r_stuff_bit;
    logic [CNT_W-1:0] r_stuff_cnt;
    logic             r_arb_lost;
    logic             r_bit_err;
    logic             r_underrun;
    logic             r_last_bit;
    logic [RUN_W-1:0] r_run_cnt;
    logic [FIX_W-1:0] r_fix_cnt;
    logic             r_lost;
    logic             r_prev_fixed;
    logic             r_en_q;

    logic             w_active;
    logic             w_fix_entry;
    logic             w_fix_due;
    logic             w_dyn_due;
    logic             w_stuff;
    logic             w_take;
    logic             w_check;
    logic             w_arb_loss;
    logic             w_bit_err;
    logic             w_en_rise;
    logic [CNT_W-1:0] w_cnt_base;

    // Decode which action this bit time takes and whether the bus read disagrees.
    always_comb begin
        w_active    = enable_i & ~r_lost & tx_point_i & ~rst_i;
        w_fix_entry = fixed_stuff_i & ~r_prev_fixed;
        w_fix_due   = fixed_stuff_i & (r_fix_cnt == FIX_W'(FIXED_RUN));
        w_dyn_due   = ~fixed_stuff_i & (r_run_cnt == RUN_W'(STUFF_RUN));
        w_stuff     = w_fix_entry | w_fix_due | w_dyn_due;
        w_take      = w_active & ~w_stuff & bit_valid_i;
        w_check     = enable_i & ~r_lost & sample_point_i;
        w_arb_loss  = w_check & arb_i & r_tx & ~rx_i;
        w_bit_err   = w_check & ~w_arb_loss & (r_tx != rx_i);
        w_en_rise   = enable_i & ~r_en_q;
        w_cnt_base  = w_en_rise ? '0 : r_stuff_cnt;
    end

    assign bit_ready_o   = w_take;
    assign tx_o          = r_tx;
    assign stuff_bit_o   = r_stuff_bit;
    assign stuff_count_o = r_stuff_cnt;
    assign arb_lost_o    = r_arb_lost;
    assign bit_err_o     = r_bit_err;
    assign underrun_o    = r_underrun;

    // Bit-stream state: emitted bit, run/fixed counters, loss flag and pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx         <= 1'b1;
            r_stuff_bit  <= 1'b0;
            r_stuff_cnt  <= '0;
            r_arb_lost   <= 1'b0;
            r_bit_err    <= 1'b0;
            r_underrun   <= 1'b0;
            r_last_bit   <= 1'b1;
            r_run_cnt    <= '0;
            r_fix_cnt    <= '0;
            r_lost       <= 1'b0;
            r_prev_fixed <= 1'b0;
            r_en_q       <= 1'b0;
        end else begin
            r_en_q     <= enable_i;
            r_arb_lost <= 1'b0;
            r_bit_err  <= 1'b0;
            r_underrun <= 1'b0;
            if (!enable_i) begin
                // Idle: stuff count is kept for the upper layer until the next frame.
                r_tx         <= 1'b1;
                r_stuff_bit  <= 1'b0;
                r_last_bit   <= 1'b1;
                r_run_cnt    <= '0;
                r_fix_cnt    <= '0;
                r_lost       <= 1'b0;
                r_prev_fixed <= 1'b0;
            end else begin
                r_stuff_cnt <= w_cnt_base;
                if (w_active) begin
                    r_prev_fixed <= fixed_stuff_i;
                    if (w_stuff) begin
                        r_tx        <= ~r_last_bit;
                        r_stuff_bit <= 1'b1;
                        r_last_bit  <= ~r_last_bit;
                        if (w_dyn_due) begin
                            r_run_cnt   <= RUN_W'(1);
                            r_stuff_cnt <= w_cnt_base + CNT_W'(1);
                        end else begin
                            r_fix_cnt <= '0;
                        end
                    end else if (bit_valid_i) begin
                        r_tx        <= bit_i;
                        r_stuff_bit <= 1'b0;
                        r_last_bit  <= bit_i;
                        if (fixed_stuff_i) begin
                            r_fix_cnt <= r_fix_cnt + FIX_W'(1);
                        end else if (bit_i == r_last_bit) begin
                            r_run_cnt <= r_run_cnt + RUN_W'(1);
                        end else begin
                            r_run_cnt <= RUN_W'(1);
                        end
                    end else begin
                        r_tx        <= 1'b1;
                        r_stuff_bit <= 1'b0;
                        r_underrun  <= 1'b1;
                    end
                end
                // Loss overrides any bit launched in the same cycle; TX goes recessive.
                if (w_arb_loss) begin
                    r_arb_lost  <= 1'b1;
                    r_lost      <= 1'b1;
                    r_tx        <= 1'b1;
                    r_stuff_bit <= 1'b0;
                end
                if (w_bit_err) begin
                    r_bit_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_can_fd_tx_bit_stuffer.sv
// Randomized frames checked against a bit-history reference model of the stuffer.
module tb_can_fd_tx_bit_stuffer;
    localparam int unsigned STUFF_RUN = 5;
    localparam int unsigned FIXED_RUN = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int          NFRAMES   = 60;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             enable_i = 1'b0;
    logic             tx_point_i = 1'b0;
    logic             sample_point_i = 1'b0;
    logic             rx_i = 1'b1;
    logic             arb_i = 1'b0;
    logic             fixed_stuff_i = 1'b0;
    logic             bit_valid_i = 1'b0;
    logic             bit_i = 1'b0;
    logic             bit_ready_o;
    logic             tx_o;
    logic             stuff_bit_o;
    logic [CNT_W-1:0] stuff_count_o;
    logic             arb_lost_o;
    logic             bit_err_o;
    logic             underrun_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: history of emitted bits rather than counters.
    bit emitted[$];
    bit dyn[$];
    int m_fixdata = 0;
    int m_nstuff  = 0;
    bit m_prev_fixed = 1'b0;
    bit m_lost = 1'b0;
    bit m_en_q = 1'b0;
    bit m_tx = 1'b1;
    bit m_sb = 1'b0;
    bit m_al = 1'b0;
    bit m_be = 1'b0;
    bit m_ur = 1'b0;

    can_fd_tx_bit_stuffer #(
        .STUFF_RUN(STUFF_RUN),
        .FIXED_RUN(FIXED_RUN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .tx_point_i    (tx_point_i),
        .sample_point_i(sample_point_i),
        .rx_i          (rx_i),
        .arb_i         (arb_i),
        .fixed_stuff_i (fixed_stuff_i),
        .bit_valid_i   (bit_valid_i),
        .bit_i         (bit_i),
        .bit_ready_o   (bit_ready_o),
        .tx_o          (tx_o),
        .stuff_bit_o   (stuff_bit_o),
        .stuff_count_o (stuff_count_o),
        .arb_lost_o    (arb_lost_o),
        .bit_err_o     (bit_err_o),
        .underrun_o    (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Length of the trailing run of equal bits in the dynamically stuffed stream.
    function automatic int trailing_run();
        int n;
        n = 0;
        if (dyn.size() == 0) return 0;
        for (int i = dyn.size() - 1; i >= 0; i--) begin
            if (dyn[i] == dyn[dyn.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic bit last_emitted();
        if (emitted.size() == 0) return 1'b1;
        return emitted[emitted.size() - 1];
    endfunction

    task automatic model_clear();
        emitted.delete();
        dyn.delete();
        m_fixdata    = 0;
        m_prev_fixed = 1'b0;
        m_lost       = 1'b0;
        m_en_q       = 1'b0;
        m_tx         = 1'b1;
        m_sb         = 1'b0;
    endtask

    // One clock: drive at negedge, check ready combinationally, check registers after posedge.
    task automatic run_cycle(input bit en, input bit txp, input bit sp, input bit arb,
                             input bit fs, input bit vld, input bit b, input bit inj,
                             input bit rs, output bit took);
        bit act, entry, fdue, ddue, want_ready, old_tx, was_lost, lastb, rxv;
        @(negedge clk_i);
        rxv = (sp && inj) ? ~m_tx : m_tx;
        enable_i       = en;
        tx_point_i     = txp;
        sample_point_i = sp;
        arb_i          = arb;
        fixed_stuff_i  = fs;
        bit_valid_i    = vld;
        bit_i          = b;
        rx_i           = rxv;
        rst_i          = rs;
        act   = en && !m_lost && txp && !rs;
        entry = fs && !m_prev_fixed;
        fdue  = fs && (m_fixdata == FIXED_RUN);
        ddue  = !fs && (trailing_run() == STUFF_RUN);
        want_ready = act && !entry && !fdue && !ddue && vld;
        #1;
        chk("bit_ready", 8'(bit_ready_o), 8'(want_ready));
        if (rs) begin
            chk("async_rst_tx", 8'(tx_o), 8'd1);
            chk("async_rst_cnt", 8'(stuff_count_o), 8'd0);
        end
        m_al = 1'b0;
        m_be = 1'b0;
        m_ur = 1'b0;
        if (rs) begin
            model_clear();
            m_nstuff = 0;
        end else if (!en) begin
            model_clear();
        end else begin
            old_tx   = m_tx;
            was_lost = m_lost;
            if (!m_en_q) m_nstuff = 0;
            m_en_q = 1'b1;
            if (act) begin
                lastb = last_emitted();
                m_prev_fixed = fs;
                if (entry || fdue) begin
                    emitted.push_back(!lastb);
                    m_tx = !lastb;
                    m_sb = 1'b1;
                    m_fixdata = 0;
                end else if (ddue) begin
                    emitted.push_back(!lastb);
                    dyn.push_back(!lastb);
                    m_tx = !lastb;
                    m_sb = 1'b1;
                    m_nstuff++;
                end else if (vld) begin
                    emitted.push_back(b);
                    m_tx = b;
                    m_sb = 1'b0;
                    if (fs) m_fixdata++;
                    else dyn.push_back(b);
                end else begin
                    m_tx = 1'b1;
                    m_sb = 1'b0;
                    m_ur = 1'b1;
                end
            end
            if (sp && !was_lost) begin
                if (arb && old_tx && !rxv) begin
                    m_al   = 1'b1;
                    m_lost = 1'b1;
                    m_tx   = 1'b1;
                    m_sb   = 1'b0;
                end else if (old_tx != rxv) begin
                    m_be = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
        chk("tx", 8'(tx_o), 8'(m_tx));
        chk("stuff_bit", 8'(stuff_bit_o), 8'(m_sb));
        chk("stuff_count", 8'(stuff_count_o), 8'(m_nstuff % 8));
        chk("arb_lost", 8'(arb_lost_o), 8'(m_al));
        chk("bit_err", 8'(bit_err_o), 8'(m_be));
        chk("underrun", 8'(underrun_o), 8'(m_ur));
        took = want_ready;
    endtask

    initial begin
        bit took, directed, constant, cur, vld, inj, rs, fs;
        int nbits, nfix;
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, took);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, took);
        run_cycle(0, 1, 0, 0, 0, 1, 0, 0, 0, took);
        for (int f = 0; f < NFRAMES; f++) begin
            directed = (f == 0);
            constant = (f % 5 == 4);
            nbits = directed ? 8 : int'($urandom_range(20, 60));
            if (directed || $urandom_range(0, 2) == 0) nfix = 0;
            else nfix = int'($urandom_range(4, 16));
            cur = directed ? 1'b0 : 1'($urandom_range(0, 1));
            for (int b = 0; b < nbits; b++) begin
                for (int c = 0; c < 4; c++) begin
                    fs  = (b >= nbits - nfix);
                    vld = (directed || constant) ? 1'b1 : ($urandom_range(0, 9) != 0);
                    inj = (c == 2) && !directed && ($urandom_range(0, 24) == 0);
                    rs  = !directed && ($urandom_range(0, 599) == 0);
                    run_cycle(1, c == 0, c == 2, b < 11, fs, vld, cur, inj, rs, took);
                    if (took && !directed && !constant && $urandom_range(0, 9) >= 7) cur = ~cur;
                end
            end
            if (directed) chk("six_zero_stuff_count", 8'(stuff_count_o), 8'd1);
            for (int i = 0; i < 3; i++) begin
                run_cycle(0, i == 1, i == 2, 0, 0, 1, 0, 0, 0, took);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
